// File: rtl/llr_input_buffer.sv
// llr_input_buffer: serial channel-LLR loader for the min-sum decoder.
// Saturates each incoming LLR to the decoder width and packs N_V of them
// into one codeword vector. Two banks let the next codeword load while
// the decoder still holds the current one.
module llr_input_buffer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IN_WIDTH = 10,
  parameter int unsigned N_V      = 44
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_llr,
  input  logic                   in_last,
  output logic [WIDTH*N_V-1:0]   all_llrs,
  output logic                   data_ready,
  input  logic                   llr_ack,
  output logic                   frame_err
);

  localparam int unsigned CNT_W   = (N_V > 1) ? $clog2(N_V) : 1;
  localparam int unsigned SAT_MAX = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [IN_WIDTH-1:0] P_SAT_POS = IN_WIDTH'(SAT_MAX);
  localparam logic signed [IN_WIDTH-1:0] P_SAT_NEG = -P_SAT_POS;
  localparam logic [CNT_W-1:0]           P_LAST_SLOT = CNT_W'(N_V - 1);

  logic [WIDTH-1:0]            r_bank [2][N_V];
  logic [1:0]                  r_full;
  logic                        r_wr_bank;
  logic                        r_rd_bank;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_frame_err;

  logic signed [IN_WIDTH-1:0]  w_in_s;
  logic [WIDTH-1:0]            w_sat;
  logic                        w_accept;
  logic                        w_last_slot;
  logic                        w_short;
  logic                        w_complete;
  logic                        w_release;

  // A full write bank means both banks are occupied, so stall the stream.
  assign in_ready    = !rst && !r_full[r_wr_bank];
  assign w_accept    = in_valid && in_ready;
  assign w_last_slot = (r_cnt == P_LAST_SLOT);
  // in_last before the final slot aborts the partial codeword.
  assign w_short     = w_accept && in_last && !w_last_slot;
  assign w_complete  = w_accept && w_last_slot;
  assign w_release   = llr_ack && r_full[r_rd_bank];

  assign data_ready  = r_full[r_rd_bank];
  assign frame_err   = r_frame_err;

  // Symmetric clamp: the most negative code is never produced.
  always_comb begin
    w_in_s = $signed(in_llr);
    if (w_in_s > P_SAT_POS) begin
      w_sat = P_SAT_POS[WIDTH-1:0];
    end else if (w_in_s < P_SAT_NEG) begin
      w_sat = P_SAT_NEG[WIDTH-1:0];
    end else begin
      w_sat = w_in_s[WIDTH-1:0];
    end
  end

  // Bank pointers, slot counter, full flags and framing-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_short || (w_complete && !in_last);

      if (w_short || w_complete) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_complete) begin
        r_wr_bank <= !r_wr_bank;
      end
      if (w_release) begin
        r_rd_bank <= !r_rd_bank;
      end

      // Fill and release always target different banks when both fire.
      for (int b = 0; b < 2; b++) begin
        if (w_complete && (r_wr_bank == 1'(b))) begin
          r_full[b] <= 1'b1;
        end else if (w_release && (r_rd_bank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  // LLR storage; an aborting word is dropped rather than written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < int'(N_V); k++) begin
          r_bank[b][k] <= '0;
        end
      end
    end else if (w_accept && !w_short) begin
      r_bank[r_wr_bank][r_cnt] <= w_sat;
    end
  end

  // Present the read bank; pure mux from registers.
  for (genvar k = 0; k < int'(N_V); k++) begin : g_out
    assign all_llrs[WIDTH*k +: WIDTH] = r_bank[r_rd_bank][k];
  end

endmodule

// File: tb/tb_llr_input_buffer.sv
// Testbench for llr_input_buffer: directed table plus randomized traffic
// checked against a frame-queue reference model.
module tb_llr_input_buffer;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned IN_WIDTH = 10;
  localparam int unsigned N_V      = 4;
  localparam int unsigned AW       = WIDTH * N_V;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_llr = '0;
  logic                in_last = 1'b0;
  logic [AW-1:0]       all_llrs;
  logic                data_ready;
  logic                llr_ack = 1'b0;
  logic                frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  llr_input_buffer #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .N_V(N_V)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_llr     (in_llr),
    .in_last    (in_last),
    .all_llrs   (all_llrs),
    .data_ready (data_ready),
    .llr_ack    (llr_ack),
    .frame_err  (frame_err)
  );

  // Reference model: queue of published codewords (at most two) plus the
  // list of LLRs collected so far for the codeword being loaded.
  logic [AW-1:0] m_q[$];
  int            m_part[$];
  bit            m_ferr = 1'b0;
  bit            m_zero = 1'b1;

  function automatic int sat(input int x);
    int lim;
    lim = (1 << (WIDTH - 1)) - 1;
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input int x, input bit last, input bit ack, input bit r);
    bit acc;
    bit rel;
    logic [AW-1:0] w;
    if (r) begin
      m_q.delete();
      m_part.delete();
      m_ferr = 1'b0;
      m_zero = 1'b1;
    end else begin
      acc = v && (m_q.size() < 2);
      rel = ack && (m_q.size() > 0);
      m_ferr = 1'b0;
      if (rel) void'(m_q.pop_front());
      if (acc) begin
        m_zero = 1'b0;
        if (last && (m_part.size() < int'(N_V) - 1)) begin
          m_part.delete();
          m_ferr = 1'b1;
        end else begin
          m_part.push_back(sat(x));
          if (m_part.size() == int'(N_V)) begin
            w = '0;
            for (int k = 0; k < int'(N_V); k++) w[WIDTH*k +: WIDTH] = WIDTH'(m_part[k]);
            m_q.push_back(w);
            m_ferr = !last;
            m_part.delete();
          end
        end
      end
    end
  endtask

  task automatic check_model(input bit r);
    chk("model_data_ready", 64'(data_ready), 64'(m_q.size() > 0));
    chk("model_in_ready", 64'(in_ready), 64'(!r && (m_q.size() < 2)));
    chk("model_frame_err", 64'(frame_err), 64'(m_ferr));
    if (m_q.size() > 0) chk("model_all_llrs", 64'(all_llrs), 64'(m_q[0]));
    else if (m_zero) chk("model_all_llrs_zero", 64'(all_llrs), 64'd0);
  endtask

  // One clock: drive inputs at the falling edge, update the model at the
  // rising edge, then compare at the next falling edge.
  task automatic tick(input bit v, input int x, input bit last, input bit ack, input bit r);
    in_valid = v;
    in_llr   = IN_WIDTH'(x);
    in_last  = last;
    llr_ack  = ack;
    rst      = r;
    @(posedge clk);
    model_step(v, x, last, ack, r);
    @(negedge clk);
    check_model(r);
  endtask

  typedef struct {
    bit            v;
    int            x;
    bit            last;
    bit            ack;
    bit            r;
    bit            e_dr;
    bit            e_ir;
    bit            e_fe;
    bit            c_all;
    logic [AW-1:0] e_all;
  } vec_t;

  vec_t tab[$];

  task automatic row(input bit v, input int x, input bit last, input bit ack, input bit r,
                     input bit e_dr, input bit e_ir, input bit e_fe, input bit c_all,
                     input logic [AW-1:0] e_all);
    vec_t t;
    t.v = v; t.x = x; t.last = last; t.ack = ack; t.r = r;
    t.e_dr = e_dr; t.e_ir = e_ir; t.e_fe = e_fe; t.c_all = c_all; t.e_all = e_all;
    tab.push_back(t);
  endtask

  initial begin
    // Reset and idle
    row(0, 0, 0, 0, 1,  0, 0, 0, 1, 32'h0);
    row(0, 0, 0, 0, 0,  0, 1, 0, 1, 32'h0);
    // Basic packing
    row(1, 5,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, -3,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 100,  0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, -7,   1, 0, 0,  1, 1, 0, 1, 32'hF964FD05);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Saturation
    row(1, 300,  0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, -300, 0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, -128, 0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 127,  1, 0, 0,  1, 1, 0, 1, 32'h7F81817F);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Short frame, then a clean frame
    row(1, 1,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 2,    1, 0, 0,  0, 1, 1, 0, 32'h0);
    row(0, 0,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 10,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 20,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 30,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 40,   1, 0, 0,  1, 1, 0, 1, 32'h281E140A);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Missing in_last on the final slot: still published, error pulses
    row(1, 1,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 2,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 3,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 4,    0, 0, 0,  1, 1, 1, 1, 32'h04030201);
    row(0, 0,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Ping-pong with back-pressure
    row(1, 1,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 2,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 3,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 4,    1, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 5,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 6,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 7,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 8,    1, 0, 0,  1, 0, 0, 1, 32'h04030201);
    row(1, 99,   0, 0, 0,  1, 0, 0, 1, 32'h04030201);
    row(0, 0,    0, 1, 0,  1, 1, 0, 1, 32'h08070605);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Last word of B on the same edge as the ack of A
    row(1, 11,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 12,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 13,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 14,   1, 0, 0,  1, 1, 0, 1, 32'h0E0D0C0B);
    row(1, 21,   0, 0, 0,  1, 1, 0, 1, 32'h0E0D0C0B);
    row(1, 22,   0, 0, 0,  1, 1, 0, 1, 32'h0E0D0C0B);
    row(1, 23,   0, 0, 0,  1, 1, 0, 1, 32'h0E0D0C0B);
    row(1, 24,   1, 1, 0,  1, 1, 0, 1, 32'h18171615);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);
    // Reset mid-load with one bank full
    row(1, 1,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 2,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 3,    0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 4,    1, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 9,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 9,    0, 0, 0,  1, 1, 0, 1, 32'h04030201);
    row(1, 9,    0, 0, 1,  0, 0, 0, 1, 32'h0);
    row(0, 0,    0, 0, 0,  0, 1, 0, 1, 32'h0);
    row(1, 49,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 50,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 51,   0, 0, 0,  0, 1, 0, 0, 32'h0);
    row(1, 52,   1, 0, 0,  1, 1, 0, 1, 32'h34333231);
    row(0, 0,    0, 1, 0,  0, 1, 0, 0, 32'h0);

    foreach (tab[i]) begin
      tick(tab[i].v, tab[i].x, tab[i].last, tab[i].ack, tab[i].r);
      chk($sformatf("row%0d_data_ready", i), 64'(data_ready), 64'(tab[i].e_dr));
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tab[i].e_ir));
      chk($sformatf("row%0d_frame_err", i), 64'(frame_err), 64'(tab[i].e_fe));
      if (tab[i].c_all) chk($sformatf("row%0d_all_llrs", i), 64'(all_llrs), 64'(tab[i].e_all));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit v, last, ack, r;
      int x;
      v    = ($urandom_range(0, 9) < 7);
      x    = int'($urandom_range(0, 1023)) - 512;
      last = (m_part.size() == int'(N_V) - 1) ^ ($urandom_range(0, 19) == 0);
      ack  = ($urandom_range(0, 9) < 3);
      r    = ($urandom_range(0, 199) == 0);
      tick(v, x, last, ack, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
